// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-road traffic phase controller with optional pedestrian request
//
// Purpose: cycles MAIN_G > MAIN_Y > CLR1 > SIDE_G > SIDE_Y > CLR2, one phase
// second per sec_tick. Main green is held while no side car and no pending
// pedestrian request.
// Optional feature macro: PED_REQ_EN (pending flag, ped_ack, ped_walk, PED_SHORT cap).
// Parameters: GREEN_MAIN, GREEN_SIDE, YELLOW, ALL_RED, PED_SHORT, each 1..63 seconds.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous, active-low reset
//   sec_tick    - one-clk pulse per second
//   sensor_side - side-road car present (level)
//   ped_req     - pedestrian button pulse
//   main_light  - {R,Y,G} one-hot, registered
//   side_light  - {R,Y,G} one-hot, registered
//   ped_walk    - walk signal for crossing the main road
//   ped_ack     - one-clk pulse when a request is latched
//   remaining   - seconds left in the current phase (never 0)
module traffic_phase_ctrl #(
  parameter int GREEN_MAIN = 20,
  parameter int GREEN_SIDE = 10,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 1,
  parameter int PED_SHORT  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       sensor_side,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [5:0] remaining
);

  typedef enum logic [2:0] {MAIN_G, MAIN_Y, CLR1, SIDE_G, SIDE_Y, CLR2} state_t;

  localparam logic [5:0] D_GM = 6'(GREEN_MAIN);
  localparam logic [5:0] D_GS = 6'(GREEN_SIDE);
  localparam logic [5:0] D_Y  = 6'(YELLOW);
  localparam logic [5:0] D_AR = 6'(ALL_RED);
  localparam logic [5:0] D_PS = 6'(PED_SHORT);

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  state_t     state, state_nxt;
  logic [5:0] rem_nxt;
  logic [2:0] main_nxt, side_nxt;
  logic       pending;
  logic       req_new;
  logic       pend_eff;

  function automatic logic [5:0] dur(input state_t s);
    case (s)
      MAIN_G:  dur = D_GM;
      MAIN_Y:  dur = D_Y;
      SIDE_G:  dur = D_GS;
      SIDE_Y:  dur = D_Y;
      default: dur = D_AR;
    endcase
  endfunction

`ifdef PED_REQ_EN
  logic pend_nxt, ack_nxt, walk_nxt, enter_side;

  assign req_new = ped_req && !pending;
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign pending        = 1'b0;
  assign req_new        = 1'b0;
  assign ped_walk       = 1'b0;
  assign ped_ack        = 1'b0;
`endif

  // A request accepted this cycle already counts, so the green cap applies
  // on the same edge the request is acknowledged.
  assign pend_eff = pending || req_new;

  // State register; lights are registered from the next state so they change
  // on the same edge as the transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLR2;
      remaining  <= D_AR;
      main_light <= L_R;
      side_light <= L_R;
    end else begin
      state      <= state_nxt;
      remaining  <= rem_nxt;
      main_light <= main_nxt;
      side_light <= side_nxt;
    end
  end

  // Next-state and phase timer.
  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    if (sec_tick && remaining == 6'd1) begin
      case (state)
        MAIN_G:  state_nxt = (sensor_side || pend_eff) ? MAIN_Y : MAIN_G;
        MAIN_Y:  state_nxt = CLR1;
        CLR1:    state_nxt = SIDE_G;
        SIDE_G:  state_nxt = SIDE_Y;
        SIDE_Y:  state_nxt = CLR2;
        default: state_nxt = MAIN_G;
      endcase
      rem_nxt = dur(state_nxt);
    end else if (state == MAIN_G && pend_eff && remaining > D_PS) begin
      rem_nxt = D_PS;
    end else if (sec_tick) begin
      rem_nxt = remaining - 6'd1;
    end
  end

  // Light decode of the next state.
  always_comb begin
    main_nxt = L_R;
    side_nxt = L_R;
    case (state_nxt)
      MAIN_G:  main_nxt = L_G;
      MAIN_Y:  main_nxt = L_Y;
      SIDE_G:  side_nxt = L_G;
      SIDE_Y:  side_nxt = L_Y;
      default: ;
    endcase
  end

`ifdef PED_REQ_EN
  assign enter_side = (state != SIDE_G) && (state_nxt == SIDE_G);

  // SIDE_G entry serves the request pending before the edge; a press on that
  // same edge opens a fresh request for the next cycle round.
  always_comb begin
    pend_nxt = pending;
    ack_nxt  = 1'b0;
    walk_nxt = ped_walk;
    if (enter_side) begin
      walk_nxt = pending;
      pend_nxt = ped_req;
      ack_nxt  = ped_req;
    end else begin
      if (req_new) begin
        pend_nxt = 1'b1;
        ack_nxt  = 1'b1;
      end
      if (state_nxt != SIDE_G) walk_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= 1'b0;
      ped_ack  <= 1'b0;
      ped_walk <= 1'b0;
    end else begin
      pending  <= pend_nxt;
      ped_ack  <= ack_nxt;
      ped_walk <= walk_nxt;
    end
  end
`endif

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter GREEN_MAIN, default 20: main-road green length, in seconds.
REQ-002 SHALL have parameter GREEN_SIDE, default 10: side-road green length, in seconds.
REQ-003 SHALL have parameter YELLOW, default 3: yellow length, in seconds, for both roads.
REQ-004 SHALL have parameter ALL_RED, default 1: all-red clearance length, in seconds.
REQ-005 SHALL have parameter PED_SHORT, default 5: cap on remaining main green once a pedestrian request is pending.
REQ-006 SHALL restrict every parameter to the range 1..63.
REQ-007 SHALL have port clk, input, 1 bit: single system clock, rising-edge active.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port sec_tick, input, 1 bit: one-clk pulse per second from the second generator.
REQ-010 SHALL have port sensor_side, input, 1 bit: car present on the side road (level).
REQ-011 SHALL have port ped_req, input, 1 bit: pedestrian button pulse.
REQ-012 SHALL have port main_light, output, 3 bits: {R,Y,G}, one-hot, registered.
REQ-013 SHALL have port side_light, output, 3 bits: {R,Y,G}, one-hot, registered.
REQ-014 SHALL have port ped_walk, output, 1 bit: walk signal for crossing the main road.
REQ-015 SHALL have port ped_ack, output, 1 bit: one-clk pulse when a request is latched.
REQ-016 SHALL have port remaining, output, 6 bits: seconds left in the current phase.

Function
REQ-017 SHALL implement states MAIN_G, MAIN_Y, CLR1, SIDE_G, SIDE_Y, CLR2, with cyclic order MAIN_G>MAIN_Y>CLR1>SIDE_G>SIDE_Y>CLR2>MAIN_G.
REQ-018 SHALL load remaining with the phase duration on entry to a phase: GREEN_MAIN, YELLOW, ALL_RED, GREEN_SIDE, YELLOW, ALL_RED respectively.
REQ-019 SHALL decrement remaining by 1 on each clk edge where sec_tick=1 and remaining>1.
REQ-020 SHALL transition on the clk edge where sec_tick=1 and remaining==1, so each phase lasts exactly its duration in ticks; remaining never reads 0.
REQ-021 SHALL make outputs follow state with no added latency, updating on the same edge as the transition.
REQ-022 SHALL drive lights per state:
- MAIN_G: main G, side R.
- MAIN_Y: main Y, side R.
- CLR1/CLR2: both R.
- SIDE_G: main R, side G.
- SIDE_Y: main R, side Y.
REQ-023 SHALL, at MAIN_G expiry with sensor_side=0 and no pending pedestrian request, stay in MAIN_G and reload GREEN_MAIN.
REQ-024 SHALL set a pending flag and pulse ped_ack for one clk when ped_req=1 and pending=0; SHALL ignore ped_req while pending=1.
REQ-025 SHALL, while in MAIN_G with pending=1 and remaining>PED_SHORT, force remaining to PED_SHORT on the next edge; this takes priority over a same-cycle sec_tick decrement.
REQ-026 SHALL assert ped_walk throughout SIDE_G only when that SIDE_G entry occurred with pending=1.
REQ-027 SHALL clear pending on entry to SIDE_G.
REQ-028 SHALL, when ped_req arrives on the same edge as SIDE_G entry, start a new pending request that is not served by this SIDE_G.
REQ-029 SHALL never drive both roads non-red in the same cycle.

Reset
REQ-030 SHALL, on reset low, asynchronously set: state=CLR2, remaining=ALL_RED, both lights R, ped_walk=0, ped_ack=0, pending=0.
REQ-031 SHALL hold these values while reset is low and resume with CLR2 timing on the first sec_tick after release.
REQ-032 SHALL, when reset is asserted mid-phase, abandon that phase with no partial completion.

Configuration
REQ-033 SHALL, with PED_REQ_EN defined, implement the pending flag, ped_ack, ped_walk and PED_SHORT logic.
REQ-034 SHALL, without PED_REQ_EN, keep the ped_req port but ignore it, tie ped_walk and ped_ack to 0, and omit the pending register; pending is treated as 0 in REQ-023.

Verification
Scenarios use GREEN_MAIN=4, GREEN_SIDE=3, YELLOW=2, ALL_RED=1, PED_SHORT=2; sec_tick every 6 clk.
REQ-035 SHALL cover: release reset, sensor_side=1, no ped -> phase tick counts 1(CLR2),4,2,1,3,2,1; remaining sequence 1,4,3,2,1,2,1,1,3,2,1,...
REQ-036 SHALL cover: sensor_side=0, no ped -> MAIN_G repeats, remaining 4,3,2,1,4,...; side_light stays R.
REQ-037 SHALL cover: PED_REQ_EN, ped_req at MAIN_G remaining=4, sensor_side=0 -> ped_ack one clk, remaining=2 next edge, then MAIN_Y, CLR1, SIDE_G with ped_walk=1 for 3 ticks.
REQ-038 SHALL cover: ped_req on the same edge as sec_tick at remaining=4 -> remaining=2, not 3.
REQ-039 SHALL cover: reset low during SIDE_G at remaining=2 -> both R and remaining=1 immediately, without waiting for clk.
REQ-040 SHALL cover: PED_REQ_EN undefined, ped_req pulsed, sensor_side=0 -> ped_ack=0, ped_walk=0, MAIN_G unchanged.
